// File: rtl/div_seq_if.sv
// Handshake/data bundle for div_seq. The div_zero signal exists only when
// DIV_FAST_ZERO_EN is defined.
interface div_seq_if #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
`ifdef DIV_FAST_ZERO_EN
  logic                      div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
`else
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder
  );
`endif
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_FAST_ZERO_EN: zero divisor bypasses iteration and raises div_zero.
module div_seq #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);
  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [DIVIDEND_WIDTH-1:0] dvd;
  logic [DIVIDEND_WIDTH-1:0] quo;
  logic [DIVISOR_WIDTH-1:0]  dvs;
  logic [DIVISOR_WIDTH-1:0]  prem;
  logic [DIVISOR_WIDTH:0]    prem_sh;
  logic [DIVISOR_WIDTH:0]    prem_diff;
  logic                      fits;
  logic                      accept;
  logic                      zero_div;

  assign accept    = bus.in_valid && (state == IDLE);
  // The stored remainder only needs DIVISOR_WIDTH bits: after each restore step
  // it is below the divisor, and for a zero divisor the top bit is shifted out next step.
  assign prem_sh   = {prem, dvd[DIVIDEND_WIDTH-1]};
  assign fits      = (prem_sh >= {1'b0, dvs});
  assign prem_diff = prem_sh - {1'b0, dvs};

`ifdef DIV_FAST_ZERO_EN
  logic dz_q;

  assign zero_div = (bus.divisor == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dz_q <= 1'b0;
    end else if (state == DONE && bus.out_ready) begin
      dz_q <= 1'b0;
    end else if (accept) begin
      dz_q <= zero_div;
    end
  end

  assign bus.div_zero = dz_q;
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_div ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dvd  <= '0;
      dvs  <= '0;
      quo  <= '0;
      prem <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd <= bus.dividend;
            dvs <= bus.divisor;
            if (zero_div) begin
              cnt  <= '0;
              quo  <= '1;
              prem <= bus.dividend[DIVISOR_WIDTH-1:0];
            end else begin
              cnt  <= CNT_W'(DIVIDEND_WIDTH);
              quo  <= '0;
              prem <= '0;
            end
          end
        end
        CALC: begin
          dvd  <= dvd << 1;
          cnt  <= cnt - CNT_W'(1);
          quo  <= {quo[DIVIDEND_WIDTH-2:0], fits};
          prem <= fits ? prem_diff[DIVISOR_WIDTH-1:0] : prem_sh[DIVISOR_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quo;
  assign bus.remainder = prem;
endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized self-checking bench for div_seq.
// Build with or without DIV_FAST_ZERO_EN; zero-divisor expectations follow the macro.
module tb_div_seq;
  localparam int DDW = 16;
  localparam int DSW = 8;
`ifdef DIV_FAST_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 17;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  div_seq_if #(.DIVIDEND_WIDTH(DDW), .DIVISOR_WIDTH(DSW)) bus ();

  div_seq #(.DIVIDEND_WIDTH(DDW), .DIVISOR_WIDTH(DSW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation; the edge inside is the accepting edge.
  task automatic start(input logic [15:0] dd, input logic [7:0] dv, input string tag);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input logic [15:0] dd, input logic [7:0] dv, input logic [15:0] eq,
                     input logic [7:0] er, input int elat, input string tag);
    int lat;
    bus.out_ready = 1'b1;
    start(dd, dv, tag);
    wait_valid(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
`ifdef DIV_FAST_ZERO_EN
    chk({tag, "_div_zero"}, 32'(bus.div_zero), 32'(dv == 8'd0));
`endif
    tick();
    chk({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
`ifdef DIV_FAST_ZERO_EN
    chk({tag, "_div_zero_after"}, 32'(bus.div_zero), 32'd0);
`endif
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          got;
    int          guard;
    int          hs_total;
    logic        hs;
    logic        seen;
    logic [15:0] dd;
    logic [15:0] q;
    logic [7:0]  dv;
    logic [7:0]  r;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
`ifdef DIV_FAST_ZERO_EN
    chk("rst_div_zero", 32'(bus.div_zero), 32'd0);
`endif
    rst = 1'b0;

    run(16'd1000, 8'd7, 16'd142, 8'd6, 17, "basic");
    run(16'd65535, 8'd255, 16'd257, 8'd0, 17, "max");
    run(16'd200, 8'd250, 16'd0, 8'd200, 17, "qzero");
    run(16'd0, 8'd1, 16'd0, 8'd0, 17, "zero_dividend");
    run(16'd5, 8'd0, 16'hFFFF, 8'h05, ZLAT, "div_by_zero");

    // Backpressure: result holds, a competing request is ignored.
    bus.out_ready = 1'b0;
    start(16'd1000, 8'd7, "bp");
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd17);
    bus.in_valid = 1'b1;
    bus.dividend = 16'd50;
    bus.divisor  = 8'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_quotient", 32'(bus.quotient), 32'd142);
      chk("bp_remainder", 32'(bus.remainder), 32'd6);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of an operation abandons it.
    bus.out_ready = 1'b1;
    start(16'd1000, 8'd7, "mid_rst");
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_quotient", 32'(bus.quotient), 32'd0);
    chk("mid_rst_remainder", 32'(bus.remainder), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    run(16'd100, 8'd9, 16'd11, 8'd1, 17, "after_rst");

    // Random operations with random consumer stalls.
    hs_total = 0;
    for (int n = 0; n < 2000; n++) begin
      dd = 16'($urandom_range(0, 65535));
      dv = 8'($urandom_range(1, 255));
      start(dd, dv, "rnd");
      got   = 0;
      guard = 0;
      q     = '0;
      r     = '0;
      while (got == 0 && guard < 300) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        hs = (bus.out_valid === 1'b1) && bus.out_ready;
        if (hs) begin
          q = bus.quotient;
          r = bus.remainder;
        end
        tick();
        guard++;
        if (hs) begin
          got = 1;
          hs_total++;
        end
      end
      chk("rnd_handshake", 32'(got), 32'd1);
      chk("rnd_identity", 32'(int'(q) * int'(dv) + int'(r)), 32'(dd));
      chk("rnd_rem_lt_div", 32'(r < dv), 32'd1);
      chk("rnd_quotient", 32'(q), 32'(dd / dv));
      chk("rnd_single_result", 32'(bus.out_valid), 32'd0);
    end
    chk("rnd_result_count", 32'(hs_total), 32'd2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential restoring divider; the inverse companion of the combinational multiplier mul_simple.
- Takes an unsigned dividend and divisor and produces quotient and remainder, one quotient bit per clock.
- Uses a valid/ready handshake on both input and output.
- Sits in the arithmetic library next to mul_simple; product-width dividends divide back by the multiplicand width.

Parameters:
- DIVIDEND_WIDTH, 16, width of dividend and quotient.
- DIVISOR_WIDTH, 8, width of divisor and remainder; must be <= DIVIDEND_WIDTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  dividend/divisor present.
- in_ready  output  1  block can accept an operation.
- dividend  input  DIVIDEND_WIDTH  unsigned dividend.
- divisor  input  DIVISOR_WIDTH  unsigned divisor.
- out_valid  output  1  quotient/remainder valid.
- out_ready  input  1  consumer takes the result.
- quotient  output  DIVIDEND_WIDTH  unsigned quotient.
- remainder  output  DIVISOR_WIDTH  unsigned remainder.
- div_zero  output  1  divisor was zero; present only with DIV_FAST_ZERO_EN.

Behaviour:
- Reset: rst sampled high at a clk edge forces the following, regardless of state:
  - state = IDLE
  - in_ready = 1, out_valid = 0
  - quotient = 0, remainder = 0, div_zero = 0
  - internal iteration counter = 0
- Reset mid-CALC or mid-DONE abandons the operation; no result is ever presented for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge, latch dividend and divisor, clear the partial remainder (DIVISOR_WIDTH+1 bits), load the counter with DIVIDEND_WIDTH, go to CALC.
- CALC:
  - in_ready = 0, out_valid = 0.
  - Each cycle: shift the partial remainder left, bringing in the next dividend MSB.
  - If partial remainder >= {1'b0, divisor}: subtract and shift quotient bit 1 in. Otherwise shift quotient bit 0 in.
  - Decrement the counter. When the counter reaches 0, go to DONE.
- Latency: out_valid rises exactly DIVIDEND_WIDTH+1 edges after the accepting edge (17 with defaults).
- DONE:
  - out_valid = 1; quotient and remainder hold constant.
  - in_ready = 0, so there is no back-to-back overlap.
  - On out_valid && out_ready at an edge, go to IDLE. in_ready = 1 from the next cycle.
  - Minimum issue interval is DIVIDEND_WIDTH+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely, with the result stable.
- Input changes while in_ready = 0 are ignored.
- Divide by zero without the macro: the normal iteration runs and yields quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0]. Latency is unchanged.
- Arithmetic is unsigned throughout.
- Results satisfy quotient*divisor + remainder == dividend and remainder < divisor, for divisor != 0.
- Outputs are registered; no combinational path from inputs to outputs other than in_ready/out_valid, which are decoded from state.

Optional Feature:
- Macro: DIV_FAST_ZERO_EN.
- Defined:
  - Port div_zero exists.
  - In IDLE, an accepted operation with divisor == 0 skips CALC and goes straight to DONE with quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], div_zero = 1.
  - out_valid rises 1 edge after the accepting edge.
  - div_zero is 0 for nonzero divisors and clears on leaving DONE.
- Not defined:
  - No div_zero port.
  - Zero divisor takes the full DIVIDEND_WIDTH+1 latency with the same quotient and remainder values.

Test Plan:
- Basic: dividend = 1000, divisor = 7, out_ready = 1 → out_valid 17 edges after accept; quotient = 142, remainder = 6; in_ready back high the following cycle.
- Extremes and quotient-zero:
  - 65535 / 255 → quotient = 257, remainder = 0.
  - 200 / 250 → quotient = 0, remainder = 200.
  - 0 / 1 → quotient = 0, remainder = 0.
- Divide by zero: 5 / 0 → quotient = 0xFFFF, remainder = 0x05.
  - Without the macro: latency 17.
  - With DIV_FAST_ZERO_EN: latency 1 and div_zero = 1.
- Backpressure: 1000 / 7 with out_ready held low 5 cycles after out_valid → outputs stable at 142/6 and in_ready = 0 throughout. A new in_valid presented meanwhile is not accepted. Release → one handshake, then IDLE.
- Reset mid-operation: assert rst 8 cycles into a 1000 / 7 operation → next cycle in_ready = 1, out_valid = 0, quotient = 0, remainder = 0. A following 100 / 9 yields 11 r 1.
- Random: 2000 random $random operations with random out_ready stalls → every result satisfies quotient*divisor + remainder == dividend and remainder < divisor (nonzero divisor); exactly one result per accepted input, in order.
